// File: rtl/encoder_pkg.sv
// Shared constants and helpers for the registered 4-to-2 encoder.
package encoder_pkg;

    // Number of request lines and the resulting index width
    localparam int ENC_N_IN = 4;
    localparam int ENC_Y_W  = 2;

    // Index codes for each request line
    localparam logic [ENC_Y_W-1:0] IDX0 = 2'd0;
    localparam logic [ENC_Y_W-1:0] IDX1 = 2'd1;
    localparam logic [ENC_Y_W-1:0] IDX2 = 2'd2;
    localparam logic [ENC_Y_W-1:0] IDX3 = 2'd3;

    // Number of set bits in a request vector (0..4 fits in 3 bits)
    function automatic logic [2:0] popcount4(input logic [ENC_N_IN-1:0] vec);
        logic [2:0] cnt;
        cnt = 3'd0;
        for (int i = 0; i < ENC_N_IN; i++) begin
            cnt = cnt + {2'b00, vec[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/encoder_4to2_core.sv
// Combinational priority encoder: highest set bit wins, plus any/multi detect.
module encoder_4to2_core
    import encoder_pkg::*;
(
    input  logic [ENC_N_IN-1:0] w,
    output logic [ENC_Y_W-1:0]  y_nxt,
    output logic                any_nxt,
    output logic                multi_nxt
);

    // Priority encode w[3] > w[2] > w[1] > w[0]; all-zero input encodes to index 0
    always_comb begin
        y_nxt = IDX0;
        casez (w)
            4'b1???: y_nxt = IDX3;
            4'b01??: y_nxt = IDX2;
            4'b001?: y_nxt = IDX1;
            4'b0001: y_nxt = IDX0;
            default: y_nxt = IDX0;
        endcase
    end

    // Activity flags: any request present, and two or more requests at once
    always_comb begin
        any_nxt   = 1'b0;
        multi_nxt = 1'b0;
        if (w != 4'b0000) begin
            any_nxt   = 1'b1;
            multi_nxt = (popcount4(w) >= 3'd2);
        end else begin
            any_nxt   = 1'b0;
            multi_nxt = 1'b0;
        end
    end

endmodule

// File: rtl/encoder_4to2.sv
// Registered 4-to-2 encoder: combinational core followed by a reset-gated output stage.
module encoder_4to2
    import encoder_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [ENC_N_IN-1:0] w,
    output logic [ENC_Y_W-1:0]  y,
    output logic                valid,
    output logic                multi
);

    logic [ENC_Y_W-1:0] y_nxt_s;
    logic               any_nxt_s;
    logic               multi_nxt_s;

    encoder_4to2_core u_core (
        .w         (w),
        .y_nxt     (y_nxt_s),
        .any_nxt   (any_nxt_s),
        .multi_nxt (multi_nxt_s)
    );

    // Output registers: reset wins over w, otherwise capture the encoded result every cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            y     <= IDX0;
            valid <= 1'b0;
            multi <= 1'b0;
        end else begin
            y     <= y_nxt_s;
            valid <= any_nxt_s;
            multi <= multi_nxt_s;
        end
    end

endmodule

// File: tb/tb_encoder_4to2.sv
// Directed scoreboard bench for the registered 4-to-2 encoder.
module tb_encoder_4to2;

    typedef struct packed {
        logic [1:0] y;
        logic       valid;
        logic       multi;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [3:0] w;
    logic [1:0] y;
    logic       valid;
    logic       multi;

    exp_t exp_q[$];
    exp_t last_obs;
    bit   have_prev;
    int   pass_cnt;
    int   total_cnt;

    encoder_4to2 dut (
        .clk   (clk),
        .rst   (rst),
        .w     (w),
        .y     (y),
        .valid (valid),
        .multi (multi)
    );

    // Free-running clock, period 10
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent reference: scan bits upward so the highest set bit is the last to win
    function automatic exp_t model(input logic rst_v, input logic [3:0] w_v);
        exp_t e;
        int   ones;
        e    = '0;
        ones = 0;
        if (!rst_v) begin
            for (int i = 0; i < 4; i++) begin
                if (w_v[i] === 1'b1) begin
                    e.y  = 2'(i);
                    ones = ones + 1;
                end
            end
            e.valid = (ones > 0);
            e.multi = (ones > 1);
        end
        return e;
    endfunction

    task automatic check_bit(input string tag, input logic obs, input logic expv);
        total_cnt++;
        assert (obs === expv) pass_cnt++;
        else $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    endtask

    task automatic check_y(input string tag, input logic [1:0] obs, input logic [1:0] expv);
        total_cnt++;
        assert (obs === expv) pass_cnt++;
        else $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    endtask

    // One directed step: drive at negedge, confirm outputs hold, then check after the edge
    task automatic step(input string tag, input logic rst_v, input logic [3:0] w_v);
        exp_t e;
        @(negedge clk);
        rst = rst_v;
        w   = w_v;
        #1;
        if (have_prev) begin
            check_y({tag, "_hold_y"}, y, last_obs.y);
            check_bit({tag, "_hold_valid"}, valid, last_obs.valid);
            check_bit({tag, "_hold_multi"}, multi, last_obs.multi);
        end
        exp_q.push_back(model(rst_v, w_v));
        @(posedge clk);
        #1;
        total_cnt++;
        assert (exp_q.size() == 1) pass_cnt++;
        else $error("FAIL %s_queue observed=%0d expected=1", tag, exp_q.size());
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_y({tag, "_y"}, y, e.y);
            check_bit({tag, "_valid"}, valid, e.valid);
            check_bit({tag, "_multi"}, multi, e.multi);
        end
        last_obs.y     = y;
        last_obs.valid = valid;
        last_obs.multi = multi;
        have_prev      = 1'b1;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        have_prev = 1'b0;
        last_obs  = '0;
        rst       = 1'b1;
        w         = 4'b1111;

        // Reset held two cycles with all requests active, then released with no requests
        step("rst_a", 1'b1, 4'b1111);
        step("rst_b", 1'b1, 4'b1111);
        step("rel0",  1'b0, 4'b0000);

        // One-hot sweep
        step("oh0", 1'b0, 4'b0001);
        step("oh1", 1'b0, 4'b0010);
        step("oh2", 1'b0, 4'b0100);
        step("oh3", 1'b0, 4'b1000);

        // Zero after 1000 must not hold index 3
        step("zero", 1'b0, 4'b0000);

        // Multi-hot priority
        step("mh0011", 1'b0, 4'b0011);
        step("mh0110", 1'b0, 4'b0110);
        step("mh1010", 1'b0, 4'b1010);
        step("mh1111", 1'b0, 4'b1111);

        // Mid-stream reset with steady w
        step("pre_rst", 1'b0, 4'b0100);
        step("mid_rst", 1'b1, 4'b0100);
        step("post_rst", 1'b0, 4'b0100);

        // Exhaustive sweep of all w values
        for (int i = 0; i < 16; i++) begin
            step($sformatf("exh%0d", i), 1'b0, 4'(i));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
